// File: rtl/cmp_seq_pkg.sv
// Shared constants for the comparator phase sequencer.
//   ST_*         : comparator state codes; the sequencer FSM encodes directly in them
//   PAD0..PAD2   : pad sub-phase indices
//   seq_state_e  : FSM state type built on the ST_* codes
//   total_bits() : number of comparator bits produced by one full run
package cmp_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_PAD   = 3'b010;
  localparam logic [2:0] ST_L1    = 3'b011;
  localparam logic [2:0] ST_L2    = 3'b100;
  localparam logic [2:0] ST_L3    = 3'b101;
  localparam logic [2:0] ST_FLUSH = 3'b110;
  localparam logic [2:0] ST_DONE  = 3'b111;

  localparam logic [1:0] PAD0 = 2'd0;
  localparam logic [1:0] PAD1 = 2'd1;
  localparam logic [1:0] PAD2 = 2'd2;

  typedef enum logic [2:0] {
    StIdle  = ST_IDLE,
    StPad   = ST_PAD,
    StL1    = ST_L1,
    StL2    = ST_L2,
    StL3    = ST_L3,
    StFlush = ST_FLUSH,
    StDone  = ST_DONE
  } seq_state_e;

  function automatic int unsigned total_bits(input int unsigned pad_len,
                                             input int unsigned l1_len,
                                             input int unsigned l2_len,
                                             input int unsigned l3_len);
    return 3 * pad_len + l1_len + l2_len + l3_len;
  endfunction

endpackage

// File: rtl/cmp_bit_packer.sv
// LSB-first bit packer with a single registered valid/ready output stage.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bit_en      : a comparator bit is valid this cycle (already qualified by the caller)
//   bit_data    : the comparator bit
//   flush       : emit a partial accumulator (acc_cnt > 0) as a zero-padded word
//   word        : packed output word
//   word_valid  : word holds valid data
//   word_ready  : downstream accepts word
//   acc_cnt     : bits currently held in the accumulator (feeds the accept rule)
module cmp_bit_packer #(
  parameter int unsigned OUT_W = 16,
  localparam int unsigned CNT_W = $clog2(OUT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             bit_data,
  input  logic             flush,
  output logic [OUT_W-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CNT_W-1:0] acc_cnt
);

  localparam int unsigned IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             full;
  logic             out_free;
  logic             load;

  always_comb begin
    full     = (cnt_q == CNT_W'(OUT_W));
    out_free = !valid_q || word_ready;
    load     = out_free && (full || (flush && (cnt_q != '0)));

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = valid_q;

    if (valid_q && word_ready) begin
      valid_d = 1'b0;
    end
    // Clearing the accumulator on load is what zero-fills the top of a partial word.
    if (load) begin
      word_d  = acc_q;
      valid_d = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
    end
    // Uses the post-load count so a bit landing with a load starts the next word.
    if (bit_en && (cnt_d != CNT_W'(OUT_W))) begin
      acc_d[cnt_d[IDX_W-1:0]] = bit_data;
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;
  assign acc_cnt    = cnt_q;

endmodule

// File: rtl/cmp_phase_sequencer.sv
// Sequences the threshold comparator through one detection run (pad sub-phases 0..2,
// then L1/L2/L3), pulls samples from the upstream stream and packs the returned
// comparator bits into OUT_W-bit words for the downstream sink.
//   iCLK, iRSTn              : clock, asynchronous active-low reset
//   iSTART                   : start-of-run pulse, honoured only in IDLE
//   iSRC_VALID / oSRC_READY  : upstream sample handshake
//   oCMP_EN, oSTATE, oPAD    : comparator enable, state code and pad index
//   iCMP_DATA, iCMP_EN       : comparator result bit and its valid (one cycle after oCMP_EN)
//   oWORD, oWORD_VALID, iWORD_READY : packed output handshake
//   oBUSY, oDONE             : run in progress, end-of-run pulse
//   oHIT_CNT                 : count of '1' bits in the run (only with CMP_SEQ_HITCNT_EN)
// Optional feature macro: CMP_SEQ_HITCNT_EN adds the saturating hit counter.
module cmp_phase_sequencer
  import cmp_seq_pkg::*;
#(
  parameter int unsigned IL      = 10,
  parameter int unsigned PAD_LEN = 16,
  parameter int unsigned L1_LEN  = 64,
  parameter int unsigned L2_LEN  = 64,
  parameter int unsigned L3_LEN  = 32,
  parameter int unsigned OUT_W   = 16
) (
  input  logic             iCLK,
  input  logic             iRSTn,
  input  logic             iSTART,
  input  logic             iSRC_VALID,
  output logic             oSRC_READY,
  output logic             oCMP_EN,
  output logic [2:0]       oSTATE,
  output logic [1:0]       oPAD,
  input  logic             iCMP_DATA,
  input  logic             iCMP_EN,
  output logic [OUT_W-1:0] oWORD,
  output logic             oWORD_VALID,
  input  logic             iWORD_READY,
  output logic             oBUSY,
`ifdef CMP_SEQ_HITCNT_EN
  output logic [15:0]      oHIT_CNT,
`endif
  output logic             oDONE
);

  localparam int unsigned CNT_W   = $clog2(OUT_W + 1);
  localparam int unsigned MAX_A   = (PAD_LEN > L1_LEN) ? PAD_LEN : L1_LEN;
  localparam int unsigned MAX_B   = (L2_LEN > L3_LEN) ? L2_LEN : L3_LEN;
  localparam int unsigned MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned PH_W    = $clog2(MAX_LEN + 1);

  localparam logic [PH_W-1:0] PAD_LAST = PH_W'(PAD_LEN - 1);
  localparam logic [PH_W-1:0] L1_LAST  = PH_W'(L1_LEN - 1);
  localparam logic [PH_W-1:0] L2_LAST  = PH_W'(L2_LEN - 1);
  localparam logic [PH_W-1:0] L3_LAST  = PH_W'(L3_LEN - 1);

  // IL only documents the sample width expected of the paired comparator.
  if (IL == 0) begin : g_bad_il
    $error("IL must be non-zero");
  end
  if (PAD_LEN == 0 || L1_LEN == 0 || L2_LEN == 0 || L3_LEN == 0 || OUT_W < 2) begin : g_bad_len
    $error("phase lengths must be non-zero and OUT_W at least 2");
  end

  seq_state_e       state_q;
  logic [1:0]       pad_q;
  logic [PH_W-1:0]  ph_cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             inflight_q;

  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W:0]   pending;
  logic             word_valid;
  logic             active;
  logic             src_ready;
  logic             cmp_en;
  logic             bit_en;
  logic             flush;
  logic             flush_done;
  logic [PH_W-1:0]  phase_last;
  logic             phase_end;

  always_comb begin
    unique case (state_q)
      StPad, StL1, StL2, StL3: active = 1'b1;
      default:                 active = 1'b0;
    endcase

    unique case (state_q)
      StL1:    phase_last = L1_LAST;
      StL2:    phase_last = L2_LAST;
      StL3:    phase_last = L3_LAST;
      default: phase_last = PAD_LAST;
    endcase

    // Bits already held plus the one still in the comparator must leave room for this one.
    pending    = {1'b0, acc_cnt} + {{CNT_W{1'b0}}, inflight_q};
    src_ready  = active && (pending < (CNT_W + 1)'(OUT_W));
    cmp_en     = src_ready && iSRC_VALID;
    phase_end  = cmp_en && (ph_cnt_q == phase_last);
    // A bit without a matching request is a protocol error and is dropped.
    bit_en     = iCMP_EN && inflight_q;
    flush      = (state_q == StFlush) && !inflight_q;
    flush_done = flush && (acc_cnt == '0) && (!word_valid || iWORD_READY);
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= cmp_en;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q  <= StIdle;
      pad_q    <= PAD0;
      ph_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iSTART) begin
            state_q  <= StPad;
            pad_q    <= PAD0;
            ph_cnt_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StPad, StL1, StL2, StL3: begin
          if (phase_end) begin
            ph_cnt_q <= '0;
            case (state_q)
              StPad: begin
                if (pad_q == PAD2) begin
                  state_q <= StL1;
                  pad_q   <= PAD0;
                end else begin
                  pad_q <= pad_q + 1'b1;
                end
              end
              StL1:    state_q <= StL2;
              StL2:    state_q <= StL3;
              default: state_q <= StFlush;
            endcase
          end else if (cmp_en) begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
          end
        end
        StFlush: begin
          if (flush_done) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  cmp_bit_packer #(
    .OUT_W(OUT_W)
  ) u_packer (
    .clk        (iCLK),
    .rst_n      (iRSTn),
    .bit_en     (bit_en),
    .bit_data   (iCMP_DATA),
    .flush      (flush),
    .word       (oWORD),
    .word_valid (word_valid),
    .word_ready (iWORD_READY),
    .acc_cnt    (acc_cnt)
  );

`ifdef CMP_SEQ_HITCNT_EN
  logic [15:0] hit_q;

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      hit_q <= '0;
    end else if ((state_q == StIdle) && iSTART) begin
      hit_q <= '0;
    end else if (bit_en && iCMP_DATA && (hit_q != 16'hFFFF)) begin
      hit_q <= hit_q + 16'd1;
    end
  end

  assign oHIT_CNT = hit_q;
`endif

  assign oSRC_READY  = src_ready;
  assign oCMP_EN     = cmp_en;
  assign oSTATE      = state_q;
  assign oPAD        = pad_q;
  assign oWORD_VALID = word_valid;
  assign oBUSY       = busy_q;
  assign oDONE       = done_q;

endmodule

// File: tb/tb_cmp_phase_sequencer.sv
// Bench for cmp_phase_sequencer: instance 0 uses default lengths, instance 1 has L3_LEN=30
// to exercise the zero-padded partial word. A comparator model answers each accepted
// sample one cycle later; the answered bit is pushed to a scoreboard and popped when the
// sink accepts a word.
module tb_cmp_phase_sequencer;

  localparam int PAD_N = 16;
  localparam int L1_N  = 64;
  localparam int L2_N  = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start      [2];
  logic        src_valid  [2];
  logic        src_ready  [2];
  logic        cmp_en_o   [2];
  logic [2:0]  state      [2];
  logic [1:0]  pad        [2];
  logic        cmp_data   [2];
  logic        cmp_en_i   [2];
  logic [15:0] word       [2];
  logic        word_valid [2];
  logic        word_ready [2];
  logic        busy       [2];
  logic        done       [2];
`ifdef CMP_SEQ_HITCNT_EN
  logic [15:0] hit_cnt    [2];
`endif

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cmp_phase_sequencer #(
      .L3_LEN(g == 0 ? 32 : 30)
    ) u_dut (
      .iCLK        (clk),
      .iRSTn       (rst_n),
      .iSTART      (start[g]),
      .iSRC_VALID  (src_valid[g]),
      .oSRC_READY  (src_ready[g]),
      .oCMP_EN     (cmp_en_o[g]),
      .oSTATE      (state[g]),
      .oPAD        (pad[g]),
      .iCMP_DATA   (cmp_data[g]),
      .iCMP_EN     (cmp_en_i[g]),
      .oWORD       (word[g]),
      .oWORD_VALID (word_valid[g]),
      .iWORD_READY (word_ready[g]),
      .oBUSY       (busy[g]),
`ifdef CMP_SEQ_HITCNT_EN
      .oHIT_CNT    (hit_cnt[g]),
`endif
      .oDONE       (done[g])
    );
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          sb_q[$];
  logic        pend_en;
  logic        pend_bit;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected {state, pad} for the idx-th accepted sample of a run.
  function automatic logic [4:0] exp_phase(input int idx);
    if (idx < PAD_N)                return {3'b010, 2'd0};
    if (idx < 2 * PAD_N)            return {3'b010, 2'd1};
    if (idx < 3 * PAD_N)            return {3'b010, 2'd2};
    if (idx < 3 * PAD_N + L1_N)     return {3'b011, 2'd0};
    if (idx < 3 * PAD_N + L1_N + L2_N) return {3'b100, 2'd0};
    return {3'b101, 2'd0};
  endfunction

  task automatic check_idle_outputs(input int s, input string tag);
    check({tag, "_ready"}, src_ready[s], 1'b0);
    check({tag, "_cmp_en"}, cmp_en_o[s], 1'b0);
    check({tag, "_state_pad"}, {state[s], pad[s]}, 5'd0);
    check({tag, "_word"}, {word_valid[s], word[s]}, 17'd0);
    check({tag, "_busy_done"}, {busy[s], done[s]}, 2'd0);
  endtask

  // One run on instance s. parity: comparator answers sample-index parity, else random.
  // stall_at/start_at/rst_at < 0 disable the sink stall, the stray iSTART and the reset.
  task automatic run(input int s, input bit parity, input int valid_pct, input int stall_at,
                     input int start_at, input int rst_at, input bit spurious);
    int          total;
    int          idx;
    int          words;
    int          dones;
    int          stall_left;
    int          stall_seen;
    int          stall_acc;
    int          n;
    int          ones;
    bit          stall_started;
    bit          start_done;
    bit          finished;
    bit          held;
    bit          b;
    logic [15:0] held_word;
    logic [15:0] exp_w;
    logic [15:0] last_word;

    total = 3 * PAD_N + L1_N + L2_N + (s == 0 ? 32 : 30);
    idx = 0; words = 0; dones = 0; stall_left = 0; stall_seen = 0; stall_acc = 0; ones = 0;
    stall_started = 0; start_done = 0; finished = 0; held = 0;
    held_word = '0; last_word = '0;
    sb_q.delete();
    pend_en = 1'b0;
    pend_bit = 1'b0;

    @(posedge clk); #1;
    start[s] = 1'b1;
    // A comparator bit with nothing in flight must not reach the accumulator.
    cmp_en_i[s] = spurious;
    cmp_data[s] = spurious;
    word_ready[s] = 1'b1;

    for (int c = 0; c < 3000 && !finished; c++) begin
      @(posedge clk); #1;
      cmp_en_i[s] = pend_en;
      cmp_data[s] = pend_bit;
      pend_en = 1'b0;
      src_valid[s] = ($urandom_range(1, 100) <= valid_pct);
      if (stall_left > 0) begin
        word_ready[s] = 1'b0;
        stall_left--;
      end else begin
        word_ready[s] = 1'b1;
      end
      if (start_at >= 0 && !start_done && idx >= start_at) begin
        start[s] = 1'b1;
        start_done = 1;
      end else begin
        start[s] = 1'b0;
      end

      @(negedge clk);
      if (c == 0) check("busy_after_start", busy[s], 1'b1);
      if (held) begin
        check("hold_valid", word_valid[s], 1'b1);
        check("hold_word", word[s], held_word);
      end
      held = word_valid[s] && !word_ready[s];
      held_word = word[s];

      if (cmp_en_o[s]) begin
        check("phase_code", exp_phase(idx), {state[s], pad[s]});
        b = parity ? idx[0] : 1'($urandom_range(0, 1));
        sb_q.push_back(b);
        ones += int'(b);
        pend_en = 1'b1;
        pend_bit = b;
        idx++;
        if (!word_ready[s]) stall_acc++;
      end

      if (word_valid[s] && word_ready[s]) begin
        n = (sb_q.size() < 16) ? sb_q.size() : 16;
        exp_w = '0;
        for (int i = 0; i < n; i++) exp_w[i] = sb_q.pop_front();
        check("word_data", word[s], exp_w);
        last_word = word[s];
        words++;
      end

      if (!word_ready[s]) begin
        stall_seen++;
        if (stall_seen == 100) begin
          check("stall_ready_low", src_ready[s], 1'b0);
          check("stall_accepts_bounded", stall_acc <= 32, 1'b1);
        end
      end

      if (done[s]) begin
        dones++;
        check("busy_in_done", busy[s], 1'b1);
        finished = 1;
      end

      if (stall_at >= 0 && !stall_started && idx >= stall_at) begin
        stall_started = 1;
        stall_left = 100;
      end

      if (rst_at >= 0 && idx >= rst_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs(s, "mid_reset");
        @(posedge clk); #1;
        src_valid[s] = 1'b0;
        cmp_en_i[s] = 1'b0;
        cmp_data[s] = 1'b0;
        sb_q.delete();
        pend_en = 1'b0;
        @(negedge clk);
        check("reset_hold_done", done[s], 1'b0);
        rst_n = 1'b1;
        return;
      end
    end

    if (!finished) check("run_timeout", 1'b0, 1'b1);

    @(posedge clk); #1;
    cmp_en_i[s] = 1'b0;
    src_valid[s] = 1'b0;
    @(negedge clk);
    check("busy_after_done", {busy[s], done[s]}, 2'b00);
    check("accept_count", idx, total);
    check("word_count", words, (total + 15) / 16);
    check("done_pulses", dones, 1);
    check("scoreboard_empty", sb_q.size(), 0);
    if (total % 16 != 0) check("partial_pad_zero", last_word >> (total % 16), 16'd0);
`ifdef CMP_SEQ_HITCNT_EN
    check("hit_count", hit_cnt[s], ones);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      src_valid[i] = 1'b0;
      cmp_data[i] = 1'b0;
      cmp_en_i[i] = 1'b0;
      word_ready[i] = 1'b0;
    end
    pend_en = 1'b0;
    pend_bit = 1'b0;

    #22;
    check_idle_outputs(0, "reset");
    src_valid[0] = 1'b1;
    #1;
    check("reset_idle_no_accept", {src_ready[0], cmp_en_o[0]}, 2'b00);
    src_valid[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b1, 100, -1, -1, -1, 1'b1);  // full run, parity data -> 0xAAAA words
    run(1, 1'b0, 100, -1, -1, -1, 1'b0);  // L3_LEN=30: 14-bit final word
    run(0, 1'b0, 100, 60, -1, -1, 1'b0);  // sink stalled 100 cycles mid-L1
    run(0, 1'b0, 60, -1, 130, -1, 1'b0);  // source gaps, stray iSTART in L2
    run(0, 1'b1, 100, -1, -1, 20, 1'b0);  // reset in pad sub-phase 1
    run(0, 1'b1, 100, -1, -1, -1, 1'b0);  // clean run after reset

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmp_phase_sequencer.md
Name: cmp_phase_sequencer

Overview:
Controller that sequences the threshold comparator through one full detection run: pad sub-phases 0..2, then layer phases L1/L2/L3. It drives the comparator's state code, pad index and enable. It pulls samples from an upstream valid/ready source and packs the registered comparator bits into OUT_W-bit words for a downstream valid/ready sink. It sits between the STFT magnitude stream and the feature buffer feeding the classifier.

Parameters:
IL, 10, sample width; informational, for checking against the comparator instance
PAD_LEN, 16, samples per pad sub-phase (3 sub-phases)
L1_LEN, 64, samples in phase L1
L2_LEN, 64, samples in phase L2
L3_LEN, 32, samples in phase L3
OUT_W, 16, bits per packed output word

Ports:
iCLK  in  1  clock
iRSTn  in  1  asynchronous active-low reset
iSTART  in  1  start-of-run pulse; ignored unless IDLE
iSRC_VALID  in  1  upstream sample available
oSRC_READY  out  1  sequencer accepts a sample this cycle
oCMP_EN  out  1  comparator iEN; high exactly on accepted-sample cycles
oSTATE  out  3  comparator current_state code
oPAD  out  2  comparator ipad index
iCMP_DATA  in  1  comparator oDATA
iCMP_EN  in  1  comparator oEN; marks iCMP_DATA valid
oWORD  out  OUT_W  packed result word
oWORD_VALID  out  1  oWORD valid
iWORD_READY  in  1  downstream accepts oWORD
oBUSY  out  1  high from the cycle after the accepted iSTART until DONE exits
oDONE  out  1  one-cycle pulse when the final word is accepted

Behaviour:
- Reset values: all outputs 0; oSTATE=3'b000; FSM=IDLE; counters, packer and output register cleared.
- State codes: IDLE 000, PAD 010, L1 011, L2 100, L3 101, FLUSH 110, DONE 111. oSTATE equals the FSM state.
- Transitions:
  - IDLE -> PAD on iSTART, with oPAD=0 and sample count=0.
  - PAD: increment oPAD after PAD_LEN accepts; after the third sub-phase (oPAD=2) -> L1.
  - L1 -> L2 -> L3 after L1_LEN, L2_LEN and L3_LEN accepts respectively.
  - L3 -> FLUSH. FLUSH -> DONE once the in-flight bit has landed and the last word has been accepted. DONE -> IDLE after one cycle.
- oPAD is 0 outside PAD.
- Each transition happens on the clock edge of the last accept, so oSTATE and oPAD are stable during every cycle oCMP_EN is high.
- Accept rule:
  - oSRC_READY = active phase (PAD/L1/L2/L3) AND (acc_cnt + inflight) < OUT_W.
  - inflight = oCMP_EN registered one cycle.
  - oCMP_EN = oSRC_READY AND iSRC_VALID.
- Latency: the bit for the sample accepted in cycle t arrives with iCMP_EN at t+1.
- Packing:
  - Each iCMP_EN shifts iCMP_DATA into the accumulator; the first bit goes to bit 0 (LSB-first). acc_cnt increments.
  - When acc_cnt==OUT_W and (oWORD_VALID==0 or iWORD_READY), the accumulator moves to oWORD, oWORD_VALID is set and acc_cnt is cleared, all in the same cycle.
  - oWORD and oWORD_VALID hold until the handshake completes.
- Backpressure: accept stalls while the accumulator is full and the output register is occupied. Lost bubble cycles are acceptable; no bit is ever dropped or duplicated.
- FLUSH: a partial accumulator (acc_cnt>0) is emitted as one word with the upper unused bits zero. acc_cnt==0 emits nothing.
- oDONE pulses in DONE. oBUSY is low in IDLE.
- iSTART while busy is ignored. iSRC_VALID in IDLE is not accepted.
- iCMP_EN arriving without a matching inflight is a protocol error. It is ignored and does not update the accumulator.
- Reset mid-run: immediate return to reset values. A partial word is discarded and no oDONE is issued.

Optional Feature:
CMP_SEQ_HITCNT_EN
- Defined: adds port oHIT_CNT out 16, counting '1' bits received during the run. Cleared on the accepted iSTART; saturates at 16'hFFFF; held after DONE until the next run.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package cmp_seq_pkg: state code constants ST_IDLE..ST_DONE, pad index constants PAD0..PAD2, and a total-bits function returning 3*PAD_LEN+L1_LEN+L2_LEN+L3_LEN.
- Sub-module cmp_bit_packer holds the accumulator, the output register and the valid/ready logic. It exports acc_cnt for the accept rule.
- The FSM and phase counters stay in the top module.

Test Plan:
- Default params, iSRC_VALID=1, iWORD_READY=1, comparator model returns sample index parity -> 208 accepts, 13 words of 0xAAAA-pattern in sequence, oDONE once.
- Phase codes: check oSTATE/oPAD on every oCMP_EN cycle -> 010/0 x16, 010/1 x16, 010/2 x16, 011 x64, 100 x64, 101 x32.
- L3_LEN=30 (206 bits) -> last word carries 14 data bits, bits 15:14 = 0.
- iWORD_READY=0 for 100 cycles mid-L1 -> oSRC_READY drops within 2 words; oWORD stable; after release, all 208 bits delivered in order.
- Random iSRC_VALID gaps plus iSTART pulsed during L2 -> run unaffected, no restart.
- iRSTn asserted during PAD sub-phase 1 -> all outputs 0 immediately; a subsequent iSTART gives a clean full run.
